// File: rtl/control_unit_acquisition_if.sv
// Acquisition control bundle between the front end, detection path and the fin write-side controller.
// The slave modport is the controller; the master modport is whatever drives it (top level or bench).
interface control_unit_acquisition_if #(
    parameter int DROP_WIDTH = 16
);
    logic                  start;
    logic                  abort;
    logic                  cont_mode;
    logic                  sample_valid;
    logic                  full_fin;
    logic                  end_sig;
    logic                  push_fin;
    logic                  acq_busy;
    logic                  acq_done;
    logic                  overflow;
    logic [DROP_WIDTH-1:0] drop_cnt;

    modport slave (
        input  start, abort, cont_mode, sample_valid, full_fin, end_sig,
        output push_fin, acq_busy, acq_done, overflow, drop_cnt
    );

    modport master (
        output start, abort, cont_mode, sample_valid, full_fin, end_sig,
        input  push_fin, acq_busy, acq_done, overflow, drop_cnt
    );
endinterface

// File: rtl/control_unit_acquisition.sv
// Write-side controller for the detection input FIFO: pushes one block of BLOCK_LEN samples,
// counts samples lost to a full FIFO, then waits for the detection path to finish the block.
//
// state    | meaning
// IDLE     | not acquiring; start re-arms and clears drop statistics
// ARM      | one cycle; sample counter cleared, samples ignored
// CAPTURE  | samples pushed into fin, or counted as drops while fin is full
// WAIT_END | block complete; waiting for end_sig from the detection path
module control_unit_acquisition #(
    parameter int BLOCK_LEN  = 1024,
    parameter int CNT_WIDTH  = 10,
    parameter int DROP_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    control_unit_acquisition_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        CAPTURE  = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(BLOCK_LEN - 1);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  acq_busy_q, acq_busy_d;
    logic                  acq_done_q, acq_done_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                  push;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acq_done_d = 1'b0;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        push       = 1'b0;
        // abort suppresses everything else in its cycle, including a push or a drop
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d    = ARM;
                        overflow_d = 1'b0;
                        drop_cnt_d = '0;
                    end
                end
                ARM: begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (bus.sample_valid && !bus.full_fin) begin
                        push  = 1'b1;
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = WAIT_END;
                        end
                    end else if (bus.sample_valid) begin
                        overflow_d = 1'b1;
                        if (drop_cnt_q != DROP_MAX) begin
                            drop_cnt_d = drop_cnt_q + DROP_WIDTH'(1);
                        end
                    end
                end
                WAIT_END: begin
                    if (bus.end_sig) begin
                        acq_done_d = 1'b1;
                        state_d    = bus.cont_mode ? ARM : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        acq_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acq_busy_q <= 1'b0;
            acq_done_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acq_busy_q <= acq_busy_d;
            acq_done_q <= acq_done_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.push_fin = push;
    assign bus.acq_busy = acq_busy_q;
    assign bus.acq_done = acq_done_q;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_control_unit_acquisition.sv
// Bench for control_unit_acquisition: directed scenarios plus random traffic, every cycle compared
// against a block-level behavioural model (pushes per block, total drops, pending done pulse).
module tb_control_unit_acquisition;
    localparam int BL = 4;
    localparam int CW = 2;
    localparam int DW = 2;
    localparam int DROP_SAT = (1 << DW) - 1;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_CAP  = 2;
    localparam int P_WAIT = 3;

    logic clock;
    logic reset;

    control_unit_acquisition_if #(.DROP_WIDTH(DW)) bus_if ();

    control_unit_acquisition #(
        .BLOCK_LEN (BL),
        .CNT_WIDTH (CW),
        .DROP_WIDTH(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int m_phase  = P_IDLE;
    int m_pushes = 0;
    int m_drops  = 0;
    bit m_done   = 1'b0;

    int cyc        = 0;
    int push_count = 0;
    int done_count = 0;
    int first_push = -1;
    bit cmp_en     = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase  = P_IDLE;
            m_pushes = 0;
            m_drops  = 0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (bus_if.abort) begin
                m_phase  = P_IDLE;
                m_pushes = 0;
            end else if (m_phase == P_IDLE) begin
                if (bus_if.start) begin
                    m_phase = P_ARM;
                    m_drops = 0;
                end
            end else if (m_phase == P_ARM) begin
                m_pushes = 0;
                m_phase  = P_CAP;
            end else if (m_phase == P_CAP) begin
                if (bus_if.sample_valid && !bus_if.full_fin) begin
                    m_pushes++;
                    if (m_pushes == BL) m_phase = P_WAIT;
                end else if (bus_if.sample_valid) begin
                    m_drops++;
                end
            end else if (bus_if.end_sig) begin
                m_done  = 1'b1;
                m_phase = bus_if.cont_mode ? P_ARM : P_IDLE;
            end
        end
    end

    always @(negedge clock) begin
        if (bus_if.push_fin) begin
            push_count++;
            if (first_push < 0) first_push = cyc;
        end
        if (bus_if.acq_done) done_count++;
        if (cmp_en) begin
            chk("push_fin", int'(bus_if.push_fin),
                int'(m_phase == P_CAP && bus_if.sample_valid && !bus_if.full_fin && !bus_if.abort));
            chk("acq_busy", int'(bus_if.acq_busy), int'(m_phase != P_IDLE));
            chk("acq_done", int'(bus_if.acq_done), int'(m_done));
            chk("overflow", int'(bus_if.overflow), int'(m_drops > 0));
            chk("drop_cnt", int'(bus_if.drop_cnt), (m_drops > DROP_SAT) ? DROP_SAT : m_drops);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_wait_end(input string name);
        for (int i = 0; i < 40 && m_phase != P_WAIT; i++) step();
        if (m_phase != P_WAIT) begin
            n_checks++;
            $display("FAIL %s: WAIT_END not reached within 40 cycles, phase %0d", name, m_phase);
        end
    endtask

    task automatic end_pulse();
        bus_if.end_sig = 1'b1;
        step();
        bus_if.end_sig = 1'b0;
    endtask

    initial begin
        int pc0, dc0, start_cyc;
        reset               = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.cont_mode    = 1'b0;
        bus_if.sample_valid = 1'b0;
        bus_if.full_fin     = 1'b0;
        bus_if.end_sig      = 1'b0;
        #3;
        chk("reset_busy", int'(bus_if.acq_busy), 0);
        chk("reset_push", int'(bus_if.push_fin), 0);
        chk("reset_drop", int'(bus_if.drop_cnt), 0);
        #19 reset = 1'b0;
        cmp_en = 1'b1;
        step();

        // 1: plain block with continuous samples
        bus_if.sample_valid = 1'b1;
        bus_if.start = 1'b1;
        start_cyc  = cyc;
        first_push = -1;
        pc0 = push_count;
        dc0 = done_count;
        step();
        bus_if.start = 1'b0;
        wait_wait_end("t1_wait");
        step();
        step();
        chk("t1_first_push_latency", first_push - start_cyc, 2);
        chk("t1_push_total", push_count - pc0, 4);
        chk("t1_busy_in_wait", int'(bus_if.acq_busy), 1);
        end_pulse();
        chk("t1_done_pulse", int'(bus_if.acq_done), 1);
        chk("t1_busy_fall", int'(bus_if.acq_busy), 0);
        step();
        chk("t1_done_once", done_count - dc0, 1);

        // 2: three drops interleaved with pushes
        pc0 = push_count;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            bus_if.full_fin = (i % 2 == 0 && i < 6);
            step();
        end
        bus_if.full_fin = 1'b0;
        chk("t2_push_total", push_count - pc0, 4);
        chk("t2_drop_cnt", int'(bus_if.drop_cnt), 3);
        chk("t2_overflow", int'(bus_if.overflow), 1);
        end_pulse();
        step();

        // 3: saturation, then a fresh start clears statistics
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        bus_if.full_fin = 1'b1;
        step();
        for (int i = 0; i < 6; i++) step();
        chk("t3_drop_saturated", int'(bus_if.drop_cnt), 3);
        bus_if.full_fin = 1'b0;
        wait_wait_end("t3_wait");
        end_pulse();
        step();
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        chk("t3_drop_cleared", int'(bus_if.drop_cnt), 0);
        chk("t3_overflow_cleared", int'(bus_if.overflow), 0);
        wait_wait_end("t3_wait2");
        end_pulse();
        step();

        // 4: continuous re-arm across two blocks
        pc0 = push_count;
        dc0 = done_count;
        bus_if.cont_mode = 1'b1;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        bus_if.full_fin = 1'b1;
        step();
        bus_if.full_fin = 1'b0;
        wait_wait_end("t4_wait1");
        end_pulse();
        wait_wait_end("t4_wait2");
        chk("t4_drop_kept", int'(bus_if.drop_cnt), 1);
        bus_if.cont_mode = 1'b0;
        end_pulse();
        step();
        chk("t4_push_total", push_count - pc0, 8);
        chk("t4_done_total", done_count - dc0, 2);
        chk("t4_idle", int'(bus_if.acq_busy), 0);

        // 5: abort after two pushes
        pc0 = push_count;
        dc0 = done_count;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        step();
        step();
        bus_if.abort = 1'b1;
        step();
        bus_if.abort = 1'b0;
        chk("t5_push_before_abort", push_count - pc0, 2);
        chk("t5_idle_after_abort", int'(bus_if.acq_busy), 0);
        step();
        chk("t5_no_done", done_count - dc0, 0);
        pc0 = push_count;
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        wait_wait_end("t5_wait");
        chk("t5_full_block", push_count - pc0, 4);
        end_pulse();
        step();

        // 6: async reset mid-capture
        bus_if.start = 1'b1;
        step();
        bus_if.start = 1'b0;
        step();
        bus_if.full_fin = 1'b1;
        step();
        bus_if.full_fin = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("t6_push_in_reset", int'(bus_if.push_fin), 0);
        chk("t6_busy_in_reset", int'(bus_if.acq_busy), 0);
        chk("t6_ovf_in_reset", int'(bus_if.overflow), 0);
        chk("t6_drop_in_reset", int'(bus_if.drop_cnt), 0);
        @(posedge clock);
        #3 reset = 1'b0;
        dc0 = done_count;
        step();
        end_pulse();
        step();
        chk("t6_end_in_idle_busy", int'(bus_if.acq_busy), 0);
        chk("t6_end_in_idle_done", done_count - dc0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bus_if.start        = ($urandom_range(99) < 8);
            bus_if.abort        = ($urandom_range(99) < 2);
            bus_if.sample_valid = ($urandom_range(99) < 70);
            bus_if.full_fin     = ($urandom_range(99) < 25);
            bus_if.end_sig      = ($urandom_range(99) < 20);
            if ($urandom_range(99) < 5) bus_if.cont_mode = ~bus_if.cont_mode;
            step();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/control_unit_acquisition.md
Name: control_unit_acquisition

Overview:
- Write-side controller for the energy-detection input FIFO (fin); the detection control unit is the reader of the same FIFO.
- Accepts a streaming sample strobe from the front end, gates pushes into fin per detection block of BLOCK_LEN samples, and waits for end_sig from the detection path before re-arming.
- Tracks overflow (samples dropped while fin is full) and reports block completion to the host/top level.

Parameters:
BLOCK_LEN, 1024, samples pushed per acquisition block (>=2)
CNT_WIDTH, 10, width of internal sample counter; must satisfy 2^CNT_WIDTH >= BLOCK_LEN
DROP_WIDTH, 16, width of saturating dropped-sample counter

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin acquisition; honoured only in IDLE
abort  input  1  synchronous abort, returns to IDLE from any state
cont_mode  input  1  1 = re-arm automatically after each block; sampled on leaving WAIT_END
sample_valid  input  1  front-end sample strobe, data on fin write port this cycle
full_fin  input  1  fin full flag
end_sig  input  1  block-processed pulse from detection control unit
push_fin  output  1  fin write enable
acq_busy  output  1  high in ARM, CAPTURE, WAIT_END
acq_done  output  1  one-cycle pulse when end_sig accepted in WAIT_END
overflow  output  1  sticky: at least one sample dropped since last start
drop_cnt  output  DROP_WIDTH  dropped samples since last start, saturating

Behaviour:
- Reset (async, active-high): state=IDLE, sample counter=0, push_fin=0, acq_busy=0, acq_done=0, overflow=0, drop_cnt=0.
- States: IDLE, ARM, CAPTURE, WAIT_END.
- IDLE: push_fin=0. start=1 and abort=0 -> ARM; also clears overflow and drop_cnt on the same edge.
- ARM (1 cycle): clears sample counter -> CAPTURE. Samples arriving in ARM are neither pushed nor counted as dropped.
- CAPTURE: push_fin = sample_valid & ~full_fin, combinational, zero latency (same cycle as sample). Each push increments the counter. A push with counter == BLOCK_LEN-1 -> WAIT_END; that push is the last of the block.
- sample_valid & full_fin in CAPTURE: sample dropped, overflow<=1, drop_cnt increments and saturates at all-ones. A dropped sample does not advance the counter.
- WAIT_END: push_fin=0; samples ignored, not counted as drops. end_sig=1 -> acq_done=1 for the next cycle (registered pulse), then ARM if cont_mode=1, else IDLE.
- Continuous re-arm does not clear overflow or drop_cnt; only start from IDLE clears them.
- end_sig outside WAIT_END: ignored.
- start outside IDLE: ignored.
- abort=1 in any state: push_fin forced 0 in that cycle (abort has priority over push); next state IDLE; counter cleared; no acq_done. overflow and drop_cnt are retained.
- Simultaneous start and abort in IDLE: abort wins and the state stays IDLE.
- acq_busy is registered from the state (high exactly while state != IDLE).
- Reset asserted mid-block: immediate return to reset values. fin is not cleared by this block; the detection unit owns sclr_fin.

Test Plan:
1. BLOCK_LEN=4: reset, start, sample_valid continuously high, full_fin=0 -> push_fin high for exactly 4 cycles starting 2 cycles after start; state WAIT_END; end_sig pulse -> acq_done high 1 cycle; acq_busy falls.
2. full_fin=1 during 3 of the capture cycles with sample_valid high -> overflow=1, drop_cnt=3, still exactly 4 pushes total before WAIT_END.
3. DROP_WIDTH=2, hold full_fin=1 for 6 valid samples -> drop_cnt saturates at 3; a new start from IDLE clears it to 0 and overflow to 0.
4. cont_mode=1, end_sig in WAIT_END -> ARM then CAPTURE with no start needed; 8 total pushes across two blocks; acq_done pulses twice; drop_cnt not cleared between blocks.
5. abort asserted after 2 pushes with sample_valid=1 and full_fin=0 -> push_fin=0 that cycle, IDLE next cycle, no acq_done. Subsequent start gives a full 4-push block.
6. Async reset asserted mid-CAPTURE between clock edges -> push_fin, acq_busy, overflow and drop_cnt all 0 immediately; end_sig in IDLE has no effect.
